ccc_apb_cfg_master: RTL and testbench

// - APB initiator for the fabric CCC's dynamic-reconfiguration port: turns single host commands into APB reads/writes.
// - Optionally pulses the PLL reset after a write, then waits for LOCK with a timeout.
// - Sits in the PCLK domain beside the u8 FCCC instance; drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA/PLL_ARST_N pins.

---
 rtl/ccc_apb_cfg_master.sv | 205 ++++++++++++++++++++
 tb/tb_ccc_apb_cfg_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccc_apb_cfg_master.sv
// rtl/ccc_apb_cfg_master.sv - APB initiator for the fabric CCC dynamic-reconfiguration port
//
// Purpose:
//   Turns single host commands into APB reads/writes on the CCC configuration
//   port. A write may optionally pulse PLL_ARST_N low and then wait for the
//   synchronised LOCK, with a timeout.
//
// Optional feature macro: CCC_CFG_READBACK_EN
//   Defined:   every write is followed by an APB read of the same address.
//              The read value is returned, and a mismatch with the written data
//              sets rsp_err.
//   Undefined: no readback. rsp_err on a write reports only a lock timeout.
//
// Ports:
//   PCLK, PRESET_N              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready       command handshake (accepted when both high)
//   cmd_write, cmd_relock       1=write / run PLL relock after the write
//   cmd_addr, cmd_wdata         command address / write data
//   rsp_valid                   one-cycle completion pulse
//   rsp_rdata, rsp_err          response data / error, held until next response
//   lock_sync                   LOCK after the synchroniser
//   PSEL, PENABLE, PWRITE       APB controls to the CCC
//   PADDR, PWDATA, PRDATA       APB address / write data / read data
//   BUSY                        CCC busy, stretches the ACCESS phase
//   LOCK                        asynchronous PLL lock from the CCC
//   PLL_ARST_N                  PLL reset to the CCC, active low

module ccc_apb_cfg_master #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int ARST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_relock,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              lock_sync,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              BUSY,
  input  logic              LOCK,
  output logic              PLL_ARST_N
);

`ifdef CCC_CFG_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  // One counter serves both ARST and LOCKWAIT, so size it for the larger.
  localparam int CNT_MAX = (ARST_CYCLES > LOCK_TIMEOUT) ? ARST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ARST_LAST = CNT_W'(ARST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  // The RB_* states are only reachable when readback is compiled in.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RB_SETUP,
    S_RB_ACCESS,
    S_ARST,
    S_LOCKWAIT,
    S_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  state_t                  w_after_wr;
  logic                    r_rst_done;
  logic                    r_write;
  logic                    r_relock;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W-1:0]       r_cap;
  logic                    r_err;
  logic [CNT_W-1:0]        r_cnt;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [DATA_W-1:0]       r_rsp_rdata;
  logic                    r_rsp_err;

  logic                    w_accept;
  logic                    w_capture;
  logic                    w_timeout;
  logic                    w_rb_mismatch;
  logic                    w_err_now;
  logic [DATA_W-1:0]       w_cap_now;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_after_wr = r_relock ? S_ARST : S_RESP;
  assign w_capture  = ((r_state == S_ACCESS) || (r_state == S_RB_ACCESS)) && !BUSY;
  // Data/error as they will be once the current cycle completes; loaded into
  // the response registers on entry to RESP so they hold between responses.
  assign w_cap_now  = w_capture ? PRDATA : r_cap;
  assign w_err_now  = r_err || w_rb_mismatch || w_timeout;

  always_comb begin
    w_next        = r_state;
    w_timeout     = 1'b0;
    w_rb_mismatch = 1'b0;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = S_SETUP;
      S_SETUP:     w_next = S_ACCESS;
      S_ACCESS: begin
        if (!BUSY) begin
          if (r_write) w_next = RB_EN ? S_RB_SETUP : w_after_wr;
          else         w_next = S_RESP;
        end
      end
      S_RB_SETUP:  w_next = S_RB_ACCESS;
      S_RB_ACCESS: begin
        if (!BUSY) begin
          w_next        = w_after_wr;
          w_rb_mismatch = (PRDATA != r_wdata);
        end
      end
      S_ARST:      if (r_cnt == ARST_LAST) w_next = S_LOCKWAIT;
      S_LOCKWAIT: begin
        // Lock takes priority over a timeout on the same cycle.
        if (lock_sync) begin
          w_next = S_RESP;
        end else if (r_cnt == LOCK_LAST) begin
          w_next    = S_RESP;
          w_timeout = 1'b1;
        end
      end
      S_RESP:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      r_state     <= S_IDLE;
      r_rst_done  <= 1'b0;
      r_write     <= 1'b0;
      r_relock    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cap       <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_sync      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rst_done <= 1'b1;
      r_sync     <= {r_sync[SYNC_STAGES-2:0], LOCK};

      if (w_accept) begin
        r_write  <= cmd_write;
        r_relock <= cmd_write && cmd_relock;
        r_addr   <= cmd_addr;
        r_wdata  <= cmd_wdata;
        r_err    <= 1'b0;
      end else if (w_rb_mismatch) begin
        r_err <= 1'b1;
      end

      if (w_capture) r_cap <= PRDATA;

      // Counter restarts at 0 on every state change.
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == S_ARST) || (r_state == S_LOCKWAIT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if ((w_next == S_RESP) && (r_state != S_RESP)) begin
        r_rsp_rdata <= w_cap_now;
        r_rsp_err   <= w_err_now;
      end
    end
  end

  assign cmd_ready  = (r_state == S_IDLE) && r_rst_done;
  assign PSEL       = (r_state == S_SETUP) || (r_state == S_ACCESS) ||
                      (r_state == S_RB_SETUP) || (r_state == S_RB_ACCESS);
  assign PENABLE    = (r_state == S_ACCESS) || (r_state == S_RB_ACCESS);
  assign PWRITE     = r_write && ((r_state == S_SETUP) || (r_state == S_ACCESS));
  assign PADDR      = r_addr;
  assign PWDATA     = r_wdata;
  assign PLL_ARST_N = (r_state != S_ARST);
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign lock_sync  = r_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// tb/tb_ccc_apb_cfg_master.sv - directed self-checking bench for ccc_apb_cfg_master

module tb_ccc_apb_cfg_master;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int ARC = 16;
  localparam int LTO = 64;
`ifdef CCC_CFG_READBACK_EN
  localparam int WR_LAT = 5;
`else
  localparam int WR_LAT = 3;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET_N = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic          cmd_relock = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          lock_sync;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          BUSY = 1'b0;
  logic          LOCK = 1'b0;
  logic          PLL_ARST_N;

  int checks = 0;
  int errors = 0;

  ccc_apb_cfg_master #(
    .ADDR_W(AW), .DATA_W(DW), .ARST_CYCLES(ARC), .LOCK_TIMEOUT(LTO), .SYNC_STAGES(2)
  ) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_relock(cmd_relock), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .lock_sync(lock_sync),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .BUSY(BUSY), .LOCK(LOCK),
    .PLL_ARST_N(PLL_ARST_N)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Waits for cmd_ready, presents one command for one cycle. Returns at the
  // falling edge of cycle N+1 (N = accept cycle).
  task automatic send_cmd(input logic w, input logic rl, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    int t;
    @(negedge PCLK);
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge PCLK);
      t++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait: got %b expected 1", cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_relock = rl;
    cmd_addr   = a;
    cmd_wdata  = d;
    @(negedge PCLK);
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    PRESET_N = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PLL_ARST_N, cmd_ready, rsp_valid, rsp_err, lock_sync} !== 8'b0001_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00010000",
               {PSEL, PENABLE, PWRITE, PLL_ARST_N, cmd_ready, rsp_valid, rsp_err, lock_sync});
    end
    checks++;
    if ({PADDR, PWDATA, rsp_rdata} !== 22'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {PADDR, PWDATA, rsp_rdata});
    end
    PRESET_N = 1'b1;
    @(negedge PCLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    PRDATA = 8'hA3;
    send_cmd(1'b1, 1'b0, 6'h05, 8'hA3);
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL write_setup: got %b expected 100", {PSEL, PENABLE, rsp_valid});
    end
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 6'h05, 8'hA3}) begin
      errors++;
      $display("FAIL write_access: got %b/%h/%h expected 111/05/a3",
               {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    for (int i = 3; i < WR_LAT; i++) begin
      @(negedge PCLK);
      checks++;
      if ({PSEL, PWRITE, rsp_valid} !== 3'b100) begin
        errors++;
        $display("FAIL write_readback_phase: got %b expected 100", {PSEL, PWRITE, rsp_valid});
      end
    end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'hA3}) begin
      errors++;
      $display("FAIL write_rsp: got %b/%h expected 10/a3", {rsp_valid, rsp_err}, rsp_rdata);
    end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata} !==
        {4'b0000, 6'h05, 8'hA3, 8'hA3}) begin
      errors++;
      $display("FAIL write_after: got %b/%h/%h/%h expected 0000/05/a3/a3",
               {rsp_valid, PSEL, PENABLE, PWRITE}, PADDR, PWDATA, rsp_rdata);
    end
  endtask

  task automatic test_read_busy();
    PRDATA = 8'hFF;
    // relock on a read must be ignored
    send_cmd(1'b0, 1'b1, 6'h12, 8'h00);
    BUSY = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 4'b1100) begin
        errors++;
        $display("FAIL read_busy_hold: got %b expected 1100", {PSEL, PENABLE, PWRITE, rsp_valid});
      end
    end
    @(negedge PCLK);
    BUSY   = 1'b0;
    PRDATA = 8'h5C;
    checks++;
    if ({PSEL, PENABLE, PADDR} !== {2'b11, 6'h12}) begin
      errors++;
      $display("FAIL read_last_access: got %b/%h expected 11/12", {PSEL, PENABLE}, PADDR);
    end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, rsp_err, PLL_ARST_N, rsp_rdata} !== {3'b101, 8'h5C}) begin
      errors++;
      $display("FAIL read_rsp: got %b/%h expected 101/5c", {rsp_valid, rsp_err, PLL_ARST_N}, rsp_rdata);
    end
  endtask

  // Runs a relock write; LOCK rises lock_after cycles after ARST ends
  // (negative = never). Checks ARST length/position and response timing.
  task automatic run_relock(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int lock_after, input int exp_k, input logic exp_err);
    int low, first_low, e, rsp_at;
    logic rerr;
    low = 0; first_low = -1; e = -1; rsp_at = -1; rerr = 1'bx;
    PRDATA = d;
    send_cmd(1'b1, 1'b1, a, d);
    for (int idx = 1; idx < 300 && rsp_at < 0; idx++) begin
      if (!PLL_ARST_N) begin
        low++;
        if (first_low < 0) first_low = idx;
      end else if (first_low >= 0 && e < 0) begin
        e = idx;
      end
      if (lock_after >= 0 && e >= 0 && idx == e + lock_after) LOCK = 1'b1;
      if (rsp_valid === 1'b1) begin
        rsp_at = idx;
        rerr   = rsp_err;
      end
      @(negedge PCLK);
    end
    checks++;
    if (first_low != WR_LAT) begin
      errors++;
      $display("FAIL %s_arst_start: got %0d expected %0d", nm, first_low, WR_LAT);
    end
    checks++;
    if (low != ARC) begin
      errors++;
      $display("FAIL %s_arst_len: got %0d expected %0d", nm, low, ARC);
    end
    checks++;
    if (rsp_at < 0 || rsp_at != e + exp_k || rerr !== exp_err) begin
      errors++;
      $display("FAIL %s_rsp: got at %0d err %b expected at %0d err %b", nm, rsp_at, rerr, e + exp_k, exp_err);
    end
  endtask

  task automatic test_relock_lock();
    LOCK = 1'b0;
    repeat (4) @(negedge PCLK);
    // LOCK at E+20, two sync flops -> lock_sync at E+22, RESP at E+23
    run_relock("relock_lock", 6'h20, 8'h41, 20, 23, 1'b0);
    checks++;
    if (lock_sync !== 1'b1) begin
      errors++;
      $display("FAIL relock_lock_sync: got %b expected 1", lock_sync);
    end
  endtask

  task automatic test_relock_timeout();
    LOCK = 1'b0;
    repeat (4) @(negedge PCLK);
    checks++;
    if (lock_sync !== 1'b0) begin
      errors++;
      $display("FAIL timeout_lock_low: got %b expected 0", lock_sync);
    end
    run_relock("timeout", 6'h21, 8'h10, -1, LTO, 1'b1);
    // next command must still be accepted
    PRDATA = 8'h99;
    send_cmd(1'b0, 1'b0, 6'h03, 8'h00);
    @(negedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h99}) begin
      errors++;
      $display("FAIL timeout_next_cmd: got %b/%h expected 10/99", {rsp_valid, rsp_err}, rsp_rdata);
    end
  endtask

  task automatic test_reset_in_arst();
    int t, pulses;
    LOCK = 1'b0;
    send_cmd(1'b1, 1'b1, 6'h07, 8'h55);
    t = 0;
    while (PLL_ARST_N !== 1'b0 && t < 20) begin
      @(negedge PCLK);
      t++;
    end
    repeat (4) @(negedge PCLK);
    checks++;
    if (PLL_ARST_N !== 1'b0) begin
      errors++;
      $display("FAIL rst_arst_entered: got %b expected 0", PLL_ARST_N);
    end
    PRESET_N = 1'b0;
    #1;
    checks++;
    if ({PLL_ARST_N, PSEL, PENABLE, cmd_ready, rsp_valid, PADDR} !== {5'b10000, 6'h00}) begin
      errors++;
      $display("FAIL rst_abort: got %b/%h expected 10000/00",
               {PLL_ARST_N, PSEL, PENABLE, cmd_ready, rsp_valid}, PADDR);
    end
    repeat (2) @(negedge PCLK);
    PRESET_N = 1'b1;
    @(negedge PCLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after: got %b expected 1", cmd_ready);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1 || PLL_ARST_N !== 1'b1) pulses++;
      @(negedge PCLK);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_no_rsp: got %0d expected 0", pulses);
    end
  endtask

`ifdef CCC_CFG_READBACK_EN
  task automatic test_readback_mismatch();
    PRDATA = 8'h32;
    send_cmd(1'b1, 1'b0, 6'h0A, 8'h33);
    repeat (3) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL rb_access: got %b expected 1100", {PSEL, PENABLE, PWRITE, rsp_valid});
    end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 8'h32}) begin
      errors++;
      $display("FAIL rb_mismatch_rsp: got %b/%h expected 11/32", {rsp_valid, rsp_err}, rsp_rdata);
    end
  endtask
`else
  task automatic test_write_rdata();
    PRDATA = 8'h77;
    send_cmd(1'b1, 1'b0, 6'h0A, 8'h33);
    repeat (2) @(negedge PCLK);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h77}) begin
      errors++;
      $display("FAIL write_prdata_rsp: got %b/%h expected 10/77", {rsp_valid, rsp_err}, rsp_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_busy();
    test_relock_lock();
    test_relock_timeout();
`ifdef CCC_CFG_READBACK_EN
    test_readback_mismatch();
`else
    test_write_rdata();
`endif
    test_reset_in_arst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
